memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//   Shares the single-port, 1-cycle-read-latency simple_memory between NUM_REQ requesters
//   (e.g. instruction fetch, load/store, DMA).
//   - Round-robin grant each cycle; one beat per grant.
//   - Drives the memory's we/addr/din; returns dout to the requester that issued the read.
//   - Sits between the requester ports and the single simple_memory instance.
// PARAMETERS
//   NUM_REQ     2   number of requesters (2..8)
//   ADDR_WIDTH  24  address width; matches simple_memory
//   DATA_WIDTH  8   data width; matches simple_memory
// PORTS
//   clk        in   1                     clock; all logic on posedge
//   rst        in   1                     synchronous, active-high reset
//   req_valid  in   NUM_REQ               per-requester request valid
//   req_ready  out  NUM_REQ               one-hot grant; beat accepted when valid&&ready
//   req_we     in   NUM_REQ               1 = write, 0 = read
//   req_addr   in   NUM_REQ*ADDR_WIDTH    packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  in   NUM_REQ*DATA_WIDTH    packed write data, same packing
//   rsp_valid  out  NUM_REQ               read data valid for requester i (one-hot or zero)
//   rsp_rdata  out  DATA_WIDTH            read data, shared; qualified by rsp_valid
//   mem_we     out  1                     to simple_memory we
//   mem_addr   out  ADDR_WIDTH            to simple_memory addr
//   mem_din    out  DATA_WIDTH            to simple_memory din
//   mem_dout   in   DATA_WIDTH            from simple_memory dout
// BEHAVIOUR
//   Reset:
//   - While rst=1: req_ready=0, mem_we=0, mem_addr=0, mem_din=0, rsp_valid=0.
//   - Round-robin pointer is 0 and the state is IDLE.
//   - No beat is accepted in a reset cycle.
//   Grant (combinational from registered pointer ptr):
//   - Winner is the first i with req_valid[i] set, searching ptr, ptr+1, ... modulo NUM_REQ.
//   - req_ready = onehot(winner); all zero if no req_valid.
//   - Exactly one beat per cycle maximum; back-to-back beats allowed every cycle.
//   Memory drive (combinational from the winner):
//   - mem_we = req_we[w], mem_addr = req_addr[w], mem_din = req_wdata[w].
//   - With no winner: mem_we=0, mem_addr=0, mem_din=0.
//   - The memory samples these on the same posedge the beat is accepted.
//   Pointer update:
//   - On an accepted beat from w, ptr <= (w+1) mod NUM_REQ.
//   - Otherwise ptr holds.
//   - Wrap-around: winner NUM_REQ-1 gives ptr 0.
//   Read response:
//   - Read accepted at edge N: rsp_valid[w]=1 and rsp_rdata=mem_dout during cycle N+1 only.
//   - Implemented as a registered one-hot rsp_sel; rsp_rdata = mem_dout passthrough.
//   - Writes produce no response.
//   - Read-before-write: a read followed next cycle by a write to the same address returns
//     the old data. A write followed next cycle by a read returns the new data.
//   Requester rules:
//   - Hold valid, we, addr and wdata stable until accepted.
//   - Dropping valid before acceptance is allowed and cancels the request.
//   - A requester that is not granted sees no side effects.
//   Reset mid-operation:
//   - A pending rsp_valid is squashed.
//   - A memory write sampled on the reset edge is suppressed, since mem_we=0 during rst.
// CONFIGURATION
//   MEM_ARB_LOCK_EN defined:
//   - Adds input port req_lock [NUM_REQ], placed after req_wdata.
//   - FSM states: IDLE, LOCKED(owner).
//   - IDLE -> LOCKED(w) on an accepted beat with req_lock[w]=1.
//   - In LOCKED, only the owner can be granted; other requesters see ready=0 even if the
//     owner is idle.
//   - LOCKED -> IDLE on an accepted owner beat with req_lock=0, or when the owner has
//     req_valid=0 and req_lock=0 together.
//   - The pointer updates only on leaving LOCKED, to owner+1.
//   MEM_ARB_LOCK_EN undefined:
//   - No req_lock port and no LOCKED state; pure per-beat round-robin.
// TESTING
//   1. Reset: hold rst 3 cycles with all req_valid=1.
//      -> req_ready=0, mem_we=0, rsp_valid=0 throughout.
//      -> First grant after reset goes to requester 0.
//   2. Single read: r0 reads 0x000010 where the preloaded hex holds 0xA5.
//      -> req_ready[0] in the same cycle; next cycle rsp_valid=01, rsp_rdata=0xA5.
//   3. Write then read: r1 writes 0x5A to 0x000020, then reads 0x000020 the next cycle.
//      -> rsp_valid[1] and 0x5A, one cycle after the read is accepted.
//   4. Contention: r0 and r1 both hold valid with reads for 6 cycles.
//      -> Grants alternate 0,1,0,1,0,1; each rsp_valid is one cycle after its grant.
//      -> No requester waits more than NUM_REQ-1 cycles.
//   5. Reset mid-read: read accepted at edge N, rst=1 in cycle N+1.
//      -> rsp_valid stays 0.
//      -> Memory contents unchanged (re-read after reset returns the old value).
//   6. (MEM_ARB_LOCK_EN) r0 runs a 4-beat burst at 0x100-0x103 with lock high on beats
//      1-3; r1 is valid throughout.
//      -> r1 is granted only on the cycle after beat 4.

Source files
------------

// File: rtl/memory_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port, 1-cycle-read memory among NUM_REQ requesters.
// Latency : grant and memory drive are combinational in the request cycle; read data returns the next cycle.
// Backpressure: req_ready is a one-hot grant; ungranted requesters hold their request and see no side effects.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; a beat is accepted when valid && ready
//   req_we/addr/wdata     per-requester command, packed with requester i at [i*W +: W]
//   req_lock              (MEM_ARB_LOCK_EN only) keep the grant on this requester after its beat
//   rsp_valid/rsp_rdata   one-hot read-response select and shared read data (memory dout passthrough)
//   mem_we/addr/din/dout  connection to the single simple_memory instance
//
// Build option: define MEM_ARB_LOCK_EN to add the req_lock port and the IDLE/LOCKED ownership FSM.
// Without it the arbiter is pure per-beat round-robin.

module memory_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_din,
    input  logic [DATA_WIDTH-1:0]         mem_dout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // (base + off) mod NUM_REQ, with off < NUM_REQ so one subtraction suffices.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] nxt_idx(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [PTR_W-1:0]   ptr;        // highest-priority requester this cycle
    logic [NUM_REQ-1:0] elig;       // requesters allowed to compete this cycle
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_nxt;
    logic [NUM_REQ-1:0] rsp_sel;    // registered one-hot owner of the read in flight

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] owner;

    // While locked, the owner is the only candidate, even if it is idle this cycle.
    always_comb begin
        elig = req_valid;
        if (state == ST_LOCKED) begin
            elig = req_valid & (ONE_HOT0 << owner);
        end
    end
`else
    assign elig = req_valid;
`endif

    // Round-robin search starting at ptr; nothing is granted while in reset.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && elig[rr_idx(ptr, k)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(ptr, k);
            end
        end
        if (rst) begin
            win_vld = 1'b0;
        end
    end

    assign win_nxt = nxt_idx(win_idx);

    // Grant and memory drive; all-zero when there is no winner.
    always_comb begin
        req_ready = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (win_vld) begin
            req_ready = ONE_HOT0 << win_idx;
            mem_we    = req_we[win_idx];
            mem_addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_din   = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            rsp_sel <= '0;
`ifdef MEM_ARB_LOCK_EN
            state   <= ST_IDLE;
            owner   <= '0;
`endif
        end else begin
            // The memory returns read data one cycle after sampling the address.
            rsp_sel <= (win_vld && !req_we[win_idx]) ? req_ready : '0;
`ifdef MEM_ARB_LOCK_EN
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        if (req_lock[win_idx]) begin
                            // Pointer is left alone; it moves past the owner on unlock.
                            state <= ST_LOCKED;
                            owner <= win_idx;
                        end else begin
                            ptr <= win_nxt;
                        end
                    end
                end
                ST_LOCKED: begin
                    // win_vld here can only be the owner's beat.
                    if (!req_lock[owner] && (win_vld || !req_valid[owner])) begin
                        state <= ST_IDLE;
                        ptr   <= nxt_idx(owner);
                    end
                end
                default: state <= ST_IDLE;
            endcase
`else
            if (win_vld) begin
                ptr <= win_nxt;
            end
`endif
        end
    end

    // A response in flight when reset arrives is squashed immediately.
    assign rsp_valid = rst ? '0 : rsp_sel;
    assign rsp_rdata = mem_dout;

endmodule
